hwag_angle_gen: RTL and testbench

- Angle generator stage directly downstream of the crank-sensor capture/gap-search core.
- Consumes the selected tooth edge strobe, the gap-confirmed sync strobe, the generator-enable flag and the latest normal tooth period.
- Subdivides each tooth pitch into 2^STEP_LOG2 equal steps by time interpolation, giving a fine crank angle counter and tick strobe for downstream ignition/injection comparators.
- Bridges the 2-tooth gap by extrapolating across GAP_TEETH pitches.

---
 rtl/hwag_angle_gen.sv | 170 +++++++++++++++++
 tb/tb_hwag_angle_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hwag_angle_gen.sv
// Crank angle generator: subdivides each tooth pitch into 2^STEP_LOG2 time-interpolated
// steps, extrapolates across the missing-tooth gap and re-anchors on every tooth edge.
module hwag_angle_gen #(
    parameter int PCNT_WIDTH  = 24,
    parameter int TCNT_WIDTH  = 6,
    parameter int STEP_LOG2   = 6,
    parameter int TOOTH_TOP   = 57,
    parameter int GAP_TEETH   = 3,
    parameter int ANGLE_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   edge_in,
    input  logic                   sync,
    input  logic                   ena,
    input  logic [PCNT_WIDTH-1:0]  period,
    output logic [ANGLE_WIDTH-1:0] angle,
    output logic                   angle_tick,
    output logic [TCNT_WIDTH-1:0]  tooth,
    output logic                   running,
    output logic                   stall,
    output logic                   lost_sync
);

    localparam int STEPS     = 1 << STEP_LOG2;
    localparam int SUB_WIDTH = $clog2(GAP_TEETH * STEPS);
    localparam logic [SUB_WIDTH-1:0]  CAP_NORM   = SUB_WIDTH'(STEPS - 1);
    localparam logic [SUB_WIDTH-1:0]  CAP_GAP    = SUB_WIDTH'(GAP_TEETH * STEPS - 1);
    localparam logic [TCNT_WIDTH-1:0] TOOTH_LAST = TCNT_WIDTH'(TOOTH_TOP);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic                   edge_q, sync_q;
    logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
    logic [TCNT_WIDTH-1:0]  tooth_q, tooth_d;
    logic [SUB_WIDTH-1:0]   sub_q, sub_d;
    logic [PCNT_WIDTH-1:0]  timer_q, timer_d;
    logic                   tick_q, tick_d;
    logic                   stall_q, stall_d;
    logic                   lost_q, lost_d;

    logic [PCNT_WIDTH-1:0]  step_period;
    logic [PCNT_WIDTH-1:0]  timer_reload;
    logic [TCNT_WIDTH-1:0]  tooth_inc;
    logic [ANGLE_WIDTH-1:0] jump_angle;
    logic [SUB_WIDTH-1:0]   cap;
    logic                   at_top;

    // A zero step period would stall the interpolator, so it is clamped to one clock.
    always_comb begin
        step_period  = period >> STEP_LOG2;
        timer_reload = (step_period == '0) ? '0 : step_period - PCNT_WIDTH'(1);
        at_top       = (tooth_q == TOOTH_LAST);
        cap          = at_top ? CAP_GAP : CAP_NORM;
        tooth_inc    = tooth_q + TCNT_WIDTH'(1);
        jump_angle   = ANGLE_WIDTH'(tooth_inc) << STEP_LOG2;
    end

    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        tooth_d = tooth_q;
        sub_d   = sub_q;
        timer_d = timer_q;
        stall_d = stall_q;
        tick_d  = 1'b0;
        lost_d  = 1'b0;

        if (!ena) begin
            state_d = IDLE;
            angle_d = '0;
            tooth_d = '0;
            sub_d   = '0;
            timer_d = '0;
            stall_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_SYNC;
                end
                WAIT_SYNC: begin
                    if (edge_q && sync_q) begin
                        state_d = RUN;
                        angle_d = '0;
                        tooth_d = '0;
                        sub_d   = '0;
                        timer_d = timer_reload;
                        stall_d = 1'b0;
                        tick_d  = 1'b1;
                    end
                end
                RUN: begin
                    // Sync is only credible on the edge that closes the gap.
                    if ((sync_q && !at_top) || (edge_q && at_top && !sync_q)) begin
                        state_d = WAIT_SYNC;
                        angle_d = '0;
                        tooth_d = '0;
                        sub_d   = '0;
                        timer_d = '0;
                        stall_d = 1'b0;
                        lost_d  = 1'b1;
                    end else if (edge_q) begin
                        sub_d   = '0;
                        timer_d = timer_reload;
                        stall_d = 1'b0;
                        tick_d  = 1'b1;
                        if (at_top) begin
                            tooth_d = '0;
                            angle_d = '0;
                        end else begin
                            tooth_d = tooth_inc;
                            angle_d = jump_angle;
                        end
                    end else if (timer_q != '0) begin
                        timer_d = timer_q - PCNT_WIDTH'(1);
                    end else if (sub_q < cap) begin
                        sub_d   = sub_q + SUB_WIDTH'(1);
                        angle_d = angle_q + ANGLE_WIDTH'(1);
                        timer_d = timer_reload;
                        tick_d  = 1'b1;
                    end else begin
                        stall_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            edge_q  <= 1'b0;
            sync_q  <= 1'b0;
            angle_q <= '0;
            tooth_q <= '0;
            sub_q   <= '0;
            timer_q <= '0;
            tick_q  <= 1'b0;
            stall_q <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_in;
            sync_q  <= sync;
            angle_q <= angle_d;
            tooth_q <= tooth_d;
            sub_q   <= sub_d;
            timer_q <= timer_d;
            tick_q  <= tick_d;
            stall_q <= stall_d;
            lost_q  <= lost_d;
        end
    end

    assign angle      = angle_q;
    assign angle_tick = tick_q;
    assign tooth      = tooth_q;
    assign running    = (state_q == RUN);
    assign stall      = stall_q;
    assign lost_sync  = lost_q;

endmodule

// File: tb/tb_hwag_angle_gen.sv
// Scoreboard bench for hwag_angle_gen: each tooth edge predicts its whole tick schedule
// from the period and edge spacing; a monitor pops predictions on every tick or lost_sync.
module tb_hwag_angle_gen;

    localparam int STEPS = 64;
    localparam int TOP   = 57;
    localparam int GAP   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        edgeIn;
    logic        syncIn;
    logic        ena;
    logic [23:0] period;
    logic [11:0] angle;
    logic        angleTick;
    logic [5:0]  tooth;
    logic        running;
    logic        stall;
    logic        lostSync;

    typedef struct {
        int kind;
        int ang;
        int tth;
        int at;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   cyc = 0;
    int   assertCount = 0;
    int   failCount = 0;
    bit   mEnabled = 0;
    bit   mSynced = 0;
    int   mTooth = 0;

    hwag_angle_gen dut (
        .clk        (clk),
        .rst        (rst),
        .edge_in    (edgeIn),
        .sync       (syncIn),
        .ena        (ena),
        .period     (period),
        .angle      (angle),
        .angle_tick (angleTick),
        .tooth      (tooth),
        .running    (running),
        .stall      (stall),
        .lost_sync  (lostSync)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every tick or lost_sync pulse must match the oldest prediction, including its cycle.
    always @(negedge clk) begin
        if (rst && (angleTick || lostSync)) begin
            assertCount++;
            if (expQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL unexpected_event: cycle %0d angle=%0d tooth=%0d tick=%0b lost=%0b, expected no event",
                         cyc, angle, tooth, angleTick, lostSync);
            end else begin
                monE = expQ.pop_front();
                if ((angleTick && lostSync) || monE.kind != (lostSync ? 1 : 0) ||
                    monE.ang != int'(angle) || monE.tth != int'(tooth) || monE.at != cyc) begin
                    failCount++;
                    $display("[TB] FAIL event_match: got kind=%0d angle=%0d tooth=%0d cycle=%0d, expected kind=%0d angle=%0d tooth=%0d cycle=%0d",
                             lostSync ? 1 : 0, angle, tooth, cyc, monE.kind, monE.ang, monE.tth, monE.at);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int expv);
        assertCount++;
        if (act != expv) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Issue one tooth edge, predict its events, then hold for d cycles and check the settled state.
    task automatic applyStimulus(input bit s, input int p, input int d);
        int t0, sp, cap, n, base, endAngle, endStall;
        bit valid;
        t0       = cyc;
        edgeIn   = 1'b1;
        syncIn   = s;
        period   = p[23:0];
        valid    = 0;
        base     = 0;
        cap      = STEPS - 1;
        sp       = 1;
        if (mEnabled) begin
            if (!mSynced) begin
                if (s) begin
                    mSynced = 1;
                    mTooth  = 0;
                    valid   = 1;
                end
            end else if (s != (mTooth == TOP)) begin
                mSynced = 0;
                mTooth  = 0;
                expQ.push_back('{1, 0, 0, t0 + 2});
            end else begin
                if (s) mTooth = 0;
                else   mTooth = mTooth + 1;
                valid = 1;
            end
        end
        if (valid) begin
            base = mTooth * STEPS;
            cap  = (mTooth == TOP) ? GAP * STEPS - 1 : STEPS - 1;
            sp   = p / STEPS;
            if (sp == 0) sp = 1;
            expQ.push_back('{0, base, mTooth, t0 + 2});
            n = (d - 1) / sp;
            if (n > cap) n = cap;
            for (int k = 1; k <= n; k++) expQ.push_back('{0, base + k, mTooth, t0 + 2 + k * sp});
        end
        @(negedge clk);
        edgeIn = 1'b0;
        syncIn = 1'b0;
        @(negedge clk);
        checkOutput("running_after_edge", int'(running), int'(mSynced));
        repeat (d - 2) @(negedge clk);
        endAngle = 0;
        endStall = 0;
        if (valid) begin
            n = (d - 2) / sp;
            if (n > cap) n = cap;
            endAngle = base + n;
            endStall = ((cap + 1) * sp <= d - 2) ? 1 : 0;
        end
        checkOutput("tooth_end_angle", int'(angle), endAngle);
        checkOutput("tooth_end_tooth", int'(tooth), valid ? mTooth : 0);
        checkOutput("tooth_end_stall", int'(stall), endStall);
        checkOutput("tooth_end_running", int'(running), int'(mSynced));
    endtask

    task automatic checkAllClear(input string tag);
        checkOutput({tag, "_angle"}, int'(angle), 0);
        checkOutput({tag, "_tooth"}, int'(tooth), 0);
        checkOutput({tag, "_running"}, int'(running), 0);
        checkOutput({tag, "_stall"}, int'(stall), 0);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b0;
        edgeIn = 1'b0;
        syncIn = 1'b0;
        ena    = 1'b0;
        period = '0;
        repeat (3) @(negedge clk);
        checkAllClear("reset");
        checkOutput("reset_tick", int'(angleTick), 0);
        checkOutput("reset_lost", int'(lostSync), 0);
        rst = 1'b1;
        @(negedge clk);

        // Disabled generator ignores edges, even sync ones.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 6400, 6);

        ena = 1'b1;
        mEnabled = 1;
        repeat (3) @(negedge clk);

        // Steady rotation, then a late edge that forces a stall.
        applyStimulus(1'b1, 6400, 6400);
        applyStimulus(1'b0, 6400, 8000);

        checkOutput("queue_empty_before_reset", expQ.size(), 0);
        rst = 1'b0;
        mSynced = 0;
        #1;
        checkAllClear("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Random fast teeth up to the gap, extrapolate across it, then wrap.
        applyStimulus(1'b1, $urandom_range(0, 1023), $urandom_range(20, 200));
        for (int i = 1; i <= TOP - 1; i++) applyStimulus(1'b0, $urandom_range(0, 1023), $urandom_range(20, 200));
        applyStimulus(1'b0, 6400, 19200);
        applyStimulus(1'b1, 640, 150);

        // Missing sync on the gap edge.
        for (int i = 1; i <= TOP; i++) applyStimulus(1'b0, $urandom_range(0, 1023), $urandom_range(20, 200));
        applyStimulus(1'b0, 640, 20);

        // Spurious sync at tooth 20.
        applyStimulus(1'b1, $urandom_range(0, 1023), $urandom_range(20, 200));
        for (int i = 1; i <= 20; i++) applyStimulus(1'b0, $urandom_range(0, 1023), $urandom_range(20, 200));
        applyStimulus(1'b1, 640, 20);

        // Minimum step period, cap at 63, and timer expiry colliding with an edge.
        applyStimulus(1'b1, 40, 64);
        applyStimulus(1'b0, 40, 100);
        applyStimulus(1'b0, 128, 100);
        applyStimulus(1'b0, 40, 100);

        ena = 1'b0;
        mEnabled = 0;
        mSynced = 0;
        @(negedge clk);
        checkAllClear("ena_drop");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 6400, 10);

        checkOutput("queue_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
